// File: rtl/clinkh32_pkg.sv
// clinkh32 shared types: FSM state enum, default ID constant, address check.
// Imported by the slave and the register bank.
package clinkh32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] ID_VALUE_DEF = 32'h4859_0001;

    // Word aligned and inside the bank.
    function automatic logic addr_ok(
        input logic [31:0] addr,
        input int unsigned nregs
    );
        return (addr[1:0] == 2'b00) && ((addr >> 2) < nregs);
    endfunction

endpackage

// File: rtl/clinkh32_if.sv
// clinkh32 CPU bus: request (rh_wl/exec/address/wr_data) and response
// (op_done/rd_data/addr_err/busy_err). master drives requests, slave responds.
interface clinkh32_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          i_rh_wl;
    logic          i_exec;
    logic [AW-1:0] i_address;
    logic [DW-1:0] i_wr_data;
    logic          o_op_done;
    logic [DW-1:0] o_rd_data;
    logic          o_addr_err;
    logic          o_busy_err;

    modport master (
        output i_rh_wl, i_exec, i_address, i_wr_data,
        input  o_op_done, o_rd_data, o_addr_err, o_busy_err
    );

    modport slave (
        input  i_rh_wl, i_exec, i_address, i_wr_data,
        output o_op_done, o_rd_data, o_addr_err, o_busy_err
    );
endinterface

// File: rtl/clinkh32_regbank.sv
// NUM_REGS x DW register bank: one write port, combinational read mux,
// flattened contents on o_regs. CLINKH32_RO_ID_EN makes reg 0 a constant ID.
module clinkh32_regbank
    import clinkh32_pkg::*;
#(
    parameter int             DW       = 32,
    parameter int             NUM_REGS = 16,
    parameter int             IW       = 4,
    parameter logic [DW-1:0]  ID_VALUE = DW'(ID_VALUE_DEF)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_we,
    input  logic [IW-1:0]          i_wr_idx,
    input  logic [DW-1:0]          i_wr_data,
    input  logic [IW-1:0]          i_rd_idx,
    output logic [DW-1:0]          o_rd_data,
    output logic [NUM_REGS*DW-1:0] o_regs
);

`ifdef CLINKH32_RO_ID_EN
    localparam bit RO_ID = 1'b1;
`else
    localparam bit RO_ID = 1'b0;
`endif

    logic [DW-1:0] w_view [NUM_REGS];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        if (RO_ID && k == 0) begin : g_id
            // No storage: writes to reg 0 vanish silently.
            assign w_view[k] = ID_VALUE;
        end else begin : g_rw
            logic [DW-1:0] r_q;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    r_q <= '0;
                else if (i_we && (int'(i_wr_idx) == k))
                    r_q <= i_wr_data;
            end
            assign w_view[k] = r_q;
        end
        assign o_regs[k*DW +: DW] = w_view[k];
    end

    always_comb begin
        o_rd_data = '0;
        if (int'(i_rd_idx) < NUM_REGS)
            o_rd_data = w_view[i_rd_idx];
    end

endmodule

// File: rtl/clinkh32_slave.sv
// clinkh32 responder: IDLE/WAIT/DONE FSM, wait counter, capture regs, error pulses.
// Ports: i_clk, i_rst_n (async low), bus (clinkh32_if.slave), o_regs. Macro: CLINKH32_RO_ID_EN.
module clinkh32_slave
    import clinkh32_pkg::*;
#(
    parameter int                    CPU_IF_AW   = 16,
    parameter int                    CPU_IF_DW   = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [CPU_IF_DW-1:0]  ID_VALUE    = CPU_IF_DW'(ID_VALUE_DEF)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    clinkh32_if.slave                     bus,
    output logic [NUM_REGS*CPU_IF_DW-1:0] o_regs
);

    localparam int DW = CPU_IF_DW;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT =
        CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_rd;
    logic          r_err;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rd_data;
    logic          r_busy_err;

    logic          w_cap;
    logic          w_in_err;
    logic [IW-1:0] w_in_idx;
    logic          w_op_rd;
    logic          w_op_err;
    logic [IW-1:0] w_op_idx;
    logic          w_we;
    logic [DW-1:0] w_bank_rd;

    assign w_in_err = !addr_ok(32'(bus.i_address), NUM_REGS);
    assign w_in_idx = bus.i_address[IW+1:2];
    assign w_cap    = (r_state == ST_IDLE) && bus.i_exec;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.i_exec)
                         w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
            ST_WAIT: if (r_cnt == '0)
                         w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_op_done  = (r_state == ST_DONE);
        bus.o_addr_err = (r_state == ST_DONE) && r_err;
        bus.o_rd_data  = r_rd_data;
        bus.o_busy_err = r_busy_err;
        w_we           = (r_state == ST_DONE) && !r_rd && !r_err;
        // With no wait states DONE is entered straight from IDLE, before
        // the capture regs hold the op, so take it from the bus then.
        w_op_rd  = r_rd;
        w_op_err = r_err;
        w_op_idx = r_idx;
        if (r_state == ST_IDLE) begin
            w_op_rd  = bus.i_rh_wl;
            w_op_err = w_in_err;
            w_op_idx = w_in_idx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_rd       <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_busy_err <= 1'b0;
        end else begin
            r_busy_err <= bus.i_exec && (r_state != ST_IDLE);
            if (w_cap) begin
                r_rd    <= bus.i_rh_wl;
                r_err   <= w_in_err;
                r_idx   <= w_in_idx;
                r_wdata <= bus.i_wr_data;
            end
            if (w_cap)
                r_cnt <= CNT_INIT;
            else if (r_state == ST_WAIT && r_cnt != '0)
                r_cnt <= r_cnt - CW'(1);
            if (w_next == ST_DONE && w_op_rd)
                r_rd_data <= w_op_err ? '0 : w_bank_rd;
        end
    end

    clinkh32_regbank #(
        .DW       (DW),
        .NUM_REGS (NUM_REGS),
        .IW       (IW),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_we      (w_we),
        .i_wr_idx  (r_idx),
        .i_wr_data (r_wdata),
        .i_rd_idx  (w_op_idx),
        .o_rd_data (w_bank_rd),
        .o_regs    (o_regs)
    );

endmodule

// File: tb/tb_clinkh32_slave.sv
// Bench for clinkh32_slave: one instance with 2 wait states, one with none,
// checked against an array model of the register bank.
module tb_clinkh32_slave;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int FW = NR * DW;
    localparam logic [31:0] IDV = 32'h4859_0001;
`ifdef CLINKH32_RO_ID_EN
    localparam bit RO = 1'b1;
`else
    localparam bit RO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clinkh32_if #(.AW(16), .DW(DW)) bus0 ();
    clinkh32_if #(.AW(16), .DW(DW)) bus1 ();
    logic [FW-1:0] regs0;
    logic [FW-1:0] regs1;

    clinkh32_slave #(.WAIT_CYCLES(2)) u_w2 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus0), .o_regs(regs0)
    );
    clinkh32_slave #(.WAIT_CYCLES(0)) u_w0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1), .o_regs(regs1)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] mdl [2][NR];
    logic [31:0] last_rd [2];

    function automatic logic [31:0] exp_reg(int d, int k);
        if (RO && k == 0) return IDV;
        return mdl[d][k];
    endfunction

    function automatic logic [FW-1:0] exp_flat(int d);
        logic [FW-1:0] f;
        for (int k = 0; k < NR; k++) f[k*DW +: DW] = exp_reg(d, k);
        return f;
    endfunction

    function automatic logic g_done(int d);
        return d == 1 ? bus1.o_op_done : bus0.o_op_done;
    endfunction
    function automatic logic g_err(int d);
        return d == 1 ? bus1.o_addr_err : bus0.o_addr_err;
    endfunction
    function automatic logic g_busy(int d);
        return d == 1 ? bus1.o_busy_err : bus0.o_busy_err;
    endfunction
    function automatic logic [31:0] g_rd(int d);
        return d == 1 ? bus1.o_rd_data : bus0.o_rd_data;
    endfunction
    function automatic logic [FW-1:0] g_regs(int d);
        return d == 1 ? regs1 : regs0;
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] obs,
                       input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit ex, input bit rw,
                         input logic [15:0] a, input logic [31:0] wd);
        if (d == 1) begin
            bus1.i_exec = ex; bus1.i_rh_wl = rw;
            bus1.i_address = a; bus1.i_wr_data = wd;
        end else begin
            bus0.i_exec = ex; bus0.i_rh_wl = rw;
            bus0.i_address = a; bus0.i_wr_data = wd;
        end
    endtask

    task automatic chk_idle_outs(input string tag, input int d);
        chk({tag, "_done"}, FW'(g_done(d)), FW'(0));
        chk({tag, "_aerr"}, FW'(g_err(d)), FW'(0));
        chk({tag, "_berr"}, FW'(g_busy(d)), FW'(0));
        chk({tag, "_rd"}, FW'(g_rd(d)), FW'(0));
        chk({tag, "_regs"}, g_regs(d), exp_flat(d));
    endtask

    // One full transaction: latency, error flag, read data, then bank view.
    task automatic op(input int d, input bit rw, input logic [15:0] a,
                      input logic [31:0] wd);
        int n;
        bit seen;
        bit err;
        int idx;
        int lat;
        logic [31:0] erd;
        lat = (d == 1) ? 1 : 3;
        err = (a[1:0] != 2'b00) || (int'(a >> 2) >= NR);
        idx = int'(a >> 2);
        @(posedge clk); #1;
        drive(d, 1'b1, rw, a, wd);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 16'h0, 32'h0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            seen = g_done(d);
        end
        chk("op_latency", FW'(n), FW'(lat));
        chk("op_addr_err", FW'(g_err(d)), FW'(err));
        if (rw) begin
            erd = err ? 32'h0 : exp_reg(d, idx);
            last_rd[d] = erd;
            chk("op_rd_data", FW'(g_rd(d)), FW'(erd));
        end else begin
            if (!err) mdl[d][idx] = wd;
            chk("op_rd_held", FW'(g_rd(d)), FW'(last_rd[d]));
        end
        @(negedge clk);
        chk("op_regs", g_regs(d), exp_flat(d));
    endtask

    initial begin
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] v3;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NR; k++) mdl[d][k] = 32'h0;
            last_rd[d] = 32'h0;
            drive(d, 1'b0, 1'b0, 16'h0, 32'h0);
        end
        repeat (2) @(negedge clk);
        chk_idle_outs("rst_w2", 0);
        chk_idle_outs("rst_w0", 1);
        rst_n = 1'b1;

        op(0, 1'b0, 16'h0008, 32'hA5A5_0001);
        op(0, 1'b1, 16'h0008, 32'h0);

        op(0, 1'b1, 16'h0003, 32'h0);
        op(0, 1'b1, 16'h0040, 32'h0);
        op(0, 1'b0, 16'h0040, $urandom);
        op(1, 1'b1, 16'h0003, 32'h0);

        v1 = $urandom; v2 = $urandom; v3 = $urandom;
        @(posedge clk); #1; drive(0, 1'b1, 1'b0, 16'h000C, v1);
        @(posedge clk); #1; drive(0, 1'b1, 1'b0, 16'h0010, v2);
        @(negedge clk);
        chk("busy_t1", FW'(g_busy(0)), FW'(0));
        chk("done_t1", FW'(g_done(0)), FW'(0));
        @(posedge clk); #1; drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        chk("busy_t2", FW'(g_busy(0)), FW'(1));
        chk("done_t2", FW'(g_done(0)), FW'(0));
        @(posedge clk); #1; drive(0, 1'b1, 1'b0, 16'h0014, v3);
        @(negedge clk);
        chk("busy_t3", FW'(g_busy(0)), FW'(0));
        chk("done_t3", FW'(g_done(0)), FW'(1));
        @(posedge clk); #1; drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        mdl[0][3] = v1;
        chk("busy_t4", FW'(g_busy(0)), FW'(1));
        chk("done_t4", FW'(g_done(0)), FW'(0));
        chk("regs_t4", g_regs(0), exp_flat(0));
        repeat (3) begin
            @(negedge clk);
            chk("done_after", FW'(g_done(0)), FW'(0));
        end

        for (int i = 0; i < 8; i++) begin
            v1 = $urandom;
            @(posedge clk); #1; drive(1, 1'b1, 1'b0, 16'(i * 4), v1);
            @(negedge clk);
            chk("w0_exec_cyc", FW'(g_done(1)), FW'(0));
            @(posedge clk); #1; drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
            @(negedge clk);
            chk("w0_done", FW'(g_done(1)), FW'(1));
            mdl[1][i] = v1;
        end
        @(negedge clk);
        chk("w0_regs8", g_regs(1), exp_flat(1));

        op(0, 1'b0, 16'h0000, 32'hFFFF_FFFF);
        op(0, 1'b1, 16'h0000, 32'h0);
        op(1, 1'b0, 16'h0000, 32'hFFFF_FFFF);
        op(1, 1'b1, 16'h0000, 32'h0);

        repeat (24) begin
            int d;
            logic [15:0] a;
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = 16'($urandom);
            else a = 16'($urandom_range(0, NR - 1) * 4);
            op(d, 1'($urandom_range(0, 1)), a, $urandom);
        end

        @(posedge clk); #1; drive(0, 1'b1, 1'b0, 16'h0004, 32'h0000_1234);
        @(posedge clk); #1; drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NR; k++) mdl[d][k] = 32'h0;
            last_rd[d] = 32'h0;
        end
        chk_idle_outs("async_w2", 0);
        chk_idle_outs("async_w0", 1);
        repeat (4) begin
            @(negedge clk);
            chk("rst_nodone", FW'(g_done(0)), FW'(0));
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_nodone", FW'(g_done(0)), FW'(0));
        end
        chk("post_rst_regs", g_regs(0), exp_flat(0));
        op(0, 1'b1, 16'h0004, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
